keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side counterpart of the calculator's multiplexed seven-segment display driver. It scans a 4x4 matrix keypad by driving one active-low column at a time, synchronizes and debounces the row returns, and emits one hex key code per press. It also accumulates decimal digits into a 16-bit, 4-digit BCD entry value that feeds the display's `displayed_num`.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell). Must be ≥ 4.
- `DEBOUNCE_COUNT`, default 4: consecutive identical row samples required to accept a press, and again to accept a release. Must be ≥ 2.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `clr_n` input 1: reset, asynchronous, active-low.
- `row_in` input 4: keypad rows, active-low with external pull-ups. Asynchronous to `clk`.
- `col_out` output 4: column drive, active-low, exactly one bit low at all times.
- `key_code` output 4: hex code of the last accepted key.
- `key_valid` output 1: one-cycle strobe when `key_code` updates.
- `key_held` output 1: high from acceptance of a press until its release is accepted.
- `entry_value` output 16: BCD digits, most recent digit in [3:0].

## Operation
- `row_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- Dwell counter `dc` runs 0..SCAN_DIV-1 and wraps. The sample point is `dc == SCAN_DIV-1`. The column changes only at wrap, and only in SCAN.
- Key map, row r (0 top) / column c (0 left):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- If several rows are low, the lowest row index wins.
- FSM states:
  - **SCAN**: at each sample point, if `rs == 4'hF`, advance the column (3 wraps to 0). Otherwise capture `rs` as `pat`, set `cnt=1`, stay on this column, and go to DEBOUNCE.
  - **DEBOUNCE**: column held. At each sample point:
    - If `rs == pat`, increment `cnt`. When `cnt` reaches DEBOUNCE_COUNT, go to PRESSED.
    - Otherwise, advance the column and return to SCAN.
  - **PRESSED**: entered for one cycle.
    - Load `key_code`, pulse `key_valid`, set `key_held`, apply the entry update.
    - Go to RELEASE with `cnt=0`.
  - **RELEASE**: column held. At each sample point:
    - If `rs == 4'hF`, increment `cnt`, else set `cnt=0`.
    - When `cnt` reaches DEBOUNCE_COUNT, clear `key_held`, advance the column, and go to SCAN.
- Entry update on acceptance:
  - Codes 0–9: `entry_value <= {entry_value[11:0], code}`. The oldest digit is discarded.
  - Code C: `entry_value <= 0`.
  - Codes A, B, D, E, F: `entry_value` unchanged (reported only).
- Only one key is tracked per press. Other keys pressed while in RELEASE are ignored until release completes.

## Timing
- Reset values:
  - `col_out = 4'b1110`
  - `key_code = 0`, `key_valid = 0`, `key_held = 0`, `entry_value = 0`
  - FSM in SCAN, `dc = 0`, synchronizer flops at `4'hF`.
- Asynchronous assertion of `clr_n` mid-press returns everything to reset values immediately. A key still held after deassertion is re-detected from SCAN and reported once.
- Synchronizer latency is 2 cycles. Settling time after a column change is SCAN_DIV-1 cycles, which exceeds that latency.
- Press latency: `key_valid` is high in the cycle after the DEBOUNCE_COUNT-th matching sample point. `key_code`, `key_held` and `entry_value` change on that same edge.
- `key_valid` is never high on two consecutive cycles.
- A full scan of all columns takes 4*SCAN_DIV cycles.
- Bounce:
  - Any mismatch during DEBOUNCE aborts the press with no output.
  - Any low row during RELEASE restarts the release count.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_COUNT=4.
- **Reset/idle:** rows all high for 200 cycles → `col_out` cycles 1110→1101→1011→0111 every 8 cycles, `key_valid` never asserts, `entry_value = 0`.
- **Clean press:** key "5" (r1, c1) held stable → exactly one `key_valid` with `key_code = 5`. `entry_value = 16'h0005`, `key_held = 1` until 4 high samples after release.
- **Entry:** press 1, 2, 3, 4, 5 in turn → `entry_value = 16'h2345`. Then C → `16'h0000`, with `key_code = 4'hC` strobed. Then A → `key_code = 4'hA`, entry unchanged.
- **Bounce:** r0 low for 2 samples, high, low 2 samples, high (on col 0) → no `key_valid`. Then held low ≥4 samples → single `key_valid`, `key_code = 1`.
- **Multi-key:** rows r0 and r2 low on col 2 → `key_code = 3`. Press "9" while "3" is still held → no second strobe. Release both → scanning resumes.
- **Reset mid-press:** assert `clr_n=0` during RELEASE → all outputs at reset values within the same cycle. Key still held at deassertion → one new strobe for the same key.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync/debounce, hex key code and BCD entry.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_COUNT = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry_value
);

    localparam int unsigned DC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_rs;
    logic [DC_W-1:0]  r_dc;
    state_t           r_state;
    logic [3:0]       r_col_out;
    logic [3:0]       r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic [15:0]      r_entry;

    logic             w_sample;
    logic [3:0]       w_col_next;
    logic [1:0]       w_col_idx;
    logic [1:0]       w_row_idx;
    logic [3:0]       w_code;
    logic [15:0]      w_entry_next;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_sample   = (r_dc == DC_LAST);
    assign w_col_next = {r_col_out[2:0], r_col_out[3]};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // Two-flop synchronizer for the asynchronous row returns
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_rs    <= r_sync1;
        end
    end

    // Dwell counter: free-running 0..SCAN_DIV-1, sample point at the top
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_dc <= '0;
        end else if (w_sample) begin
            r_dc <= '0;
        end else begin
            r_dc <= r_dc + DC_W'(1);
        end
    end

    // Decode driven column and the winning (lowest) low row into a key code
    always_comb begin
        w_col_idx = 2'd0;
        case (r_col_out)
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase

        w_row_idx = 2'd3;
        if (!r_pat[0])      w_row_idx = 2'd0;
        else if (!r_pat[1]) w_row_idx = 2'd1;
        else if (!r_pat[2]) w_row_idx = 2'd2;

        w_code = 4'h0;
        case ({w_row_idx, w_col_idx})
            4'd0:  w_code = 4'h1;
            4'd1:  w_code = 4'h2;
            4'd2:  w_code = 4'h3;
            4'd3:  w_code = 4'hA;
            4'd4:  w_code = 4'h4;
            4'd5:  w_code = 4'h5;
            4'd6:  w_code = 4'h6;
            4'd7:  w_code = 4'hB;
            4'd8:  w_code = 4'h7;
            4'd9:  w_code = 4'h8;
            4'd10: w_code = 4'h9;
            4'd11: w_code = 4'hC;
            4'd12: w_code = 4'h0;
            4'd13: w_code = 4'hF;
            4'd14: w_code = 4'hE;
            default: w_code = 4'hD;
        endcase

        w_entry_next = r_entry;
        if (w_code <= 4'd9) begin
            w_entry_next = {r_entry[11:0], w_code};
        end else if (w_code == 4'hC) begin
            w_entry_next = 16'h0000;
        end
    end

    // Scan / debounce / press / release sequencer with registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_SCAN;
            r_col_out   <= 4'b1110;
            r_pat       <= 4'hF;
            r_cnt       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_entry     <= 16'h0000;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (w_sample) begin
                        if (r_rs == 4'hF) begin
                            r_col_out <= w_col_next;
                        end else begin
                            r_pat   <= r_rs;
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_sample) begin
                        if (r_rs == r_pat) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_DONE) begin
                                // Outputs move on this edge so the strobe lands in PRESSED
                                r_key_code  <= w_code;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_entry     <= w_entry_next;
                                r_state     <= ST_PRESSED;
                            end
                        end else begin
                            r_col_out <= w_col_next;
                            r_state   <= ST_SCAN;
                        end
                    end
                end
                ST_PRESSED: begin
                    r_cnt   <= '0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (w_sample) begin
                        if (r_rs == 4'hF) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_DONE) begin
                                r_key_held <= 1'b0;
                                r_col_out  <= w_col_next;
                                r_state    <= ST_SCAN;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign col_out     = r_col_out;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_held    = r_key_held;
    assign entry_value = r_entry;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, expected-strobe scoreboard, request-driven monitor.
module tb_keypad_scanner;

    localparam int unsigned SD  = 8;
    localparam int unsigned DBC = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry_value;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_COUNT(DBC)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    // Keypad: key (r,c) at bit r*4+c pulls row r low while column c is driven low
    logic [15:0] keys;
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
    } exp_t;

    typedef struct {
        int          sel;
        logic [15:0] val;
    } req_t;

    exp_t  exp_q[$];
    req_t  req_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_strobe = 0;
    int    n_colchg = 0;
    int    strobes_exp = 0;
    int    cyc = 0;
    bit    idle_chk = 1'b0;
    bit    prev_valid = 1'b0;
    logic [3:0]  last_col = 4'b1110;
    logic [15:0] model_entry;
    logic [3:0]  keymap [4][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: reset values, scan pattern, strobe scoreboard and queued probe requests
    always @(negedge clk) begin
        exp_t e;
        req_t q;
        logic [3:0] exp_col;
        if (!clr_n) begin
            check("reset_state", 32'({col_out, key_code, key_valid, key_held, entry_value}),
                  32'({4'b1110, 4'h0, 1'b0, 1'b0, 16'h0000}));
            cyc = 0;
            prev_valid = 1'b0;
        end else begin
            if (idle_chk) begin
                exp_col = 4'hF;
                exp_col[(cyc / SD) % 4] = 1'b0;
                check("idle_col", 32'(col_out), 32'(exp_col));
            end
            check("col_one_low", 32'($countones(col_out)), 32'd3);
            if (key_valid) begin
                check("valid_not_back_to_back", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", 32'(key_code), 32'(e.code));
                    check("entry_value", 32'(entry_value), 32'(e.entry));
                    check("held_at_strobe", 32'(key_held), 32'd1);
                end
                n_strobe++;
            end
            prev_valid = key_valid;
            cyc++;
        end
        if (col_out != last_col) n_colchg++;
        last_col = col_out;
        while (req_q.size() > 0) begin
            q = req_q.pop_front();
            case (q.sel)
                0: check("key_held", 32'(key_held), 32'(q.val));
                1: check("entry_probe", 32'(entry_value), 32'(q.val));
                2: check("strobe_count", 32'(n_strobe), 32'(q.val));
                3: check("code_probe", 32'(key_code), 32'(q.val));
                4: check("scan_resumed", 32'((n_colchg - int'(q.val)) >= 4), 32'd1);
                default: check("pending_expect", 32'(exp_q.size()), 32'(q.val));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sel, input logic [15:0] val);
        req_t q;
        q.sel = sel;
        q.val = val;
        req_q.push_back(q);
    endtask

    function automatic logic [3:0] code_of(input logic [15:0] m);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r*4+c]) return keymap[r][c];
        return 4'h0;
    endfunction

    function automatic logic [15:0] apply_entry(input logic [15:0] e, input logic [3:0] code);
        if (code < 4'd10) return 16'((32'(e) * 16 + 32'(code)) % 65536);
        if (code == 4'hC) return 16'h0000;
        return e;
    endfunction

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    task automatic expect_strobe(input logic [3:0] code);
        exp_t e;
        model_entry = apply_entry(model_entry, code);
        e.code  = code;
        e.entry = model_entry;
        exp_q.push_back(e);
        strobes_exp++;
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 300 && n_strobe < strobes_exp; i++) tick(1);
        probe(2, 16'(strobes_exp));
    endtask

    task automatic press(input logic [15:0] m);
        keys = m;
        expect_strobe(code_of(m));
        wait_strobe();
    endtask

    task automatic release_all();
        keys = '0;
        for (int i = 0; i < 300 && key_held; i++) tick(1);
        probe(0, 16'd0);
    endtask

    task automatic wait_col0_start();
        for (int i = 0; i < 100 && col_out == 4'b1110; i++) tick(1);
        for (int i = 0; i < 100 && col_out != 4'b1110; i++) tick(1);
    endtask

    task automatic bounce_burst(input int low_cycles);
        wait_col0_start();
        keys = kbit(0, 0);
        tick(low_cycles);
        keys = '0;
        tick(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        keymap[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
        keymap[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
        keymap[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
        keymap[3] = '{4'h0, 4'hF, 4'hE, 4'hD};
        keys = '0;
        model_entry = 16'h0000;
        clr_n = 1'b0;
        tick(3);

        // Idle scanning
        clr_n = 1'b1;
        idle_chk = 1'b1;
        tick(200);
        idle_chk = 1'b0;
        probe(1, 16'h0000);
        probe(2, 16'd0);

        // Clean press of "5" with release timing
        press(kbit(1, 1));
        probe(1, 16'h0005);
        tick(5);
        keys = '0;
        tick(20);
        probe(0, 16'd1);
        tick(20);
        probe(0, 16'd0);
        tick(10);

        // Entry sequence, clear, non-digit key
        press(kbit(0, 0)); release_all();
        press(kbit(0, 1)); release_all();
        press(kbit(0, 2)); release_all();
        press(kbit(1, 0)); release_all();
        press(kbit(1, 1)); release_all();
        probe(1, 16'h2345);
        press(kbit(2, 3));
        probe(1, 16'h0000);
        probe(3, 16'h000C);
        release_all();
        press(kbit(0, 3));
        probe(3, 16'h000A);
        probe(1, 16'h0000);
        release_all();

        // Bounce on column 0: 2, 2 and 3 matching samples never accept
        bounce_burst(20);
        bounce_burst(20);
        bounce_burst(28);
        probe(2, 16'(strobes_exp));
        press(kbit(0, 0));
        release_all();

        // Multi-key: lowest row wins; second key during release ignored
        press(kbit(0, 2) | kbit(2, 2));
        release_all();
        press(kbit(0, 2));
        keys = keys | kbit(2, 2);
        tick(100);
        probe(2, 16'(strobes_exp));
        begin
            int c0;
            c0 = n_colchg;
            release_all();
            tick(40);
            probe(4, 16'(c0));
        end

        // Reset during release, key still held afterwards
        press(kbit(1, 1));
        tick(5);
        clr_n = 1'b0;
        model_entry = 16'h0000;
        tick(3);
        expect_strobe(4'h5);
        clr_n = 1'b1;
        wait_strobe();
        release_all();

        // Randomized single-column presses
        for (int n = 0; n < 12; n++) begin
            int          c;
            logic [3:0]  rows;
            logic [15:0] m;
            c    = $urandom_range(0, 3);
            rows = 4'($urandom_range(1, 15));
            m    = '0;
            for (int r = 0; r < 4; r++) if (rows[r]) m = m | kbit(r, c);
            press(m);
            tick($urandom_range(0, 30));
            release_all();
            tick($urandom_range(0, 20));
        end

        probe(5, 16'd0);
        probe(2, 16'(strobes_exp));
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
